// File: rtl/spi_device_pkg.sv
// Shared types and constants for the SPI device core.
package spi_device_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned CntW  = $clog2(ByteW);

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Leading edge moves SCLK away from its idle level.
  function automatic logic lead_edge(input spi_mode_t mode, input logic rise, input logic fall);
    return mode.cpol ? fall : rise;
  endfunction

  function automatic logic trail_edge(input spi_mode_t mode, input logic rise, input logic fall);
    return mode.cpol ? rise : fall;
  endfunction

endpackage

// File: rtl/spi_device_if.sv
// Byte streams between the SPI device core and its register/FIFO front-end.
interface spi_device_if;
  import spi_device_pkg::*;

  logic [ByteW-1:0] tx_data_i;
  logic             tx_valid_i;
  logic             tx_ready_o;
  logic [ByteW-1:0] rx_data_o;
  logic             rx_valid_o;
  logic             rx_ready_i;

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, rx_data_o, rx_valid_o
  );

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, rx_data_o, rx_valid_o
  );

endinterface

// File: rtl/spi_device_sync.sv
// N-stage input synchronizer with an optional registered copy for edge pulses.
module spi_device_sync #(
  parameter int unsigned Stages  = 2,
  parameter bit          EdgeDet = 1'b1
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // Synchronizer flops are deliberately unreset so a reset never fakes a pin edge.
  logic [Stages-1:0] r_sync;

  always_ff @(posedge clk_i) begin
    r_sync <= {r_sync[Stages-2:0], d_i};
  end

  assign q_o = r_sync[Stages-1];

  generate
    if (EdgeDet) begin : g_edge
      logic r_prev;

      always_ff @(posedge clk_i) begin
        r_prev <= r_sync[Stages-1];
      end

      assign rise_o = r_sync[Stages-1] & ~r_prev;
      assign fall_o = ~r_sync[Stages-1] & r_prev;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_device_core.sv
// SPI target, all four modes, MSB-first bytes; SPI pins oversampled in clk_i.
module spi_device_core
  import spi_device_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         cpol_i,
  input  logic         cpha_i,
  input  logic         sclk_i,
  input  logic         cs_i,
  input  logic         mosi_i,
  output logic         miso_o,
  output logic         miso_en_o,
  spi_device_if.slave  stream,
  output logic         rx_overflow_o,
  output logic         tx_underflow_o,
  output logic         active_o
);

  logic w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
  logic w_cs_rise, w_cs_fall, w_cs_level_unused;
  logic w_mosi_sync, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_device_sync #(.Stages(SyncStages), .EdgeDet(1'b1)) u_sync_sclk (
    .clk_i  (clk_i),
    .d_i    (sclk_i),
    .q_o    (w_sclk_level_unused),
    .rise_o (w_sclk_rise),
    .fall_o (w_sclk_fall)
  );

  spi_device_sync #(.Stages(SyncStages), .EdgeDet(1'b1)) u_sync_cs (
    .clk_i  (clk_i),
    .d_i    (cs_i),
    .q_o    (w_cs_level_unused),
    .rise_o (w_cs_rise),
    .fall_o (w_cs_fall)
  );

  spi_device_sync #(.Stages(SyncStages), .EdgeDet(1'b0)) u_sync_mosi (
    .clk_i  (clk_i),
    .d_i    (mosi_i),
    .q_o    (w_mosi_sync),
    .rise_o (w_mosi_rise_unused),
    .fall_o (w_mosi_fall_unused)
  );

  spi_mode_t w_mode;
  logic      w_lead, w_trail, w_sample_edge, w_launch_edge;

  assign w_mode        = '{cpol: cpol_i, cpha: cpha_i};
  assign w_lead        = lead_edge(w_mode, w_sclk_rise, w_sclk_fall);
  assign w_trail       = trail_edge(w_mode, w_sclk_rise, w_sclk_fall);
  assign w_sample_edge = w_mode.cpha ? w_trail : w_lead;
  assign w_launch_edge = w_mode.cpha ? w_lead : w_trail;

  state_e r_state, w_state_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en_i && w_cs_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (!en_i || w_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    miso_en_o = 1'b0;
    active_o  = 1'b0;
    if (r_state == ACTIVE) begin
      miso_en_o = 1'b1;
      active_o  = 1'b1;
    end
  end

  logic w_enter, w_stay, w_launch, w_sample;

  assign w_enter  = (r_state == IDLE) && (w_state_nxt == ACTIVE);
  assign w_stay   = (r_state == ACTIVE) && (w_state_nxt == ACTIVE);
  // With CPHA=0 the first bit must be on MISO before the first (sampling) edge.
  assign w_launch = (w_stay && w_launch_edge) || (w_enter && !w_mode.cpha);
  assign w_sample = w_stay && w_sample_edge;

  logic [CntW-1:0]  r_tx_cnt, r_rx_cnt, w_tx_cnt_cur;
  logic [ByteW-1:0] r_tx_shift, r_rx_shift, r_rx_data;
  logic [ByteW-1:0] w_tx_src, w_rx_byte;
  logic             r_pend_pop, r_miso, r_tx_ready, r_rx_valid, r_ovf, r_unf;

  assign w_tx_cnt_cur = w_enter ? '0 : r_tx_cnt;
  assign w_tx_src     = (w_tx_cnt_cur != '0) ? r_tx_shift :
                        (stream.tx_valid_i ? stream.tx_data_i : '0);
  assign w_rx_byte    = {r_rx_shift[ByteW-2:0], w_mosi_sync};

  // Peek at launch, pop only at the byte's first sample edge, so a byte
  // peeked just before CS release stays queued for the next transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_pend_pop <= 1'b0;
      r_miso     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_tx_ready <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;

      if (w_enter) begin
        r_tx_cnt   <= '0;
        r_rx_cnt   <= '0;
        r_pend_pop <= 1'b0;
      end

      if (w_launch) begin
        r_miso     <= w_tx_src[ByteW-1];
        r_tx_shift <= {w_tx_src[ByteW-2:0], 1'b0};
        r_tx_cnt   <= w_tx_cnt_cur + CntW'(1);
        if (w_tx_cnt_cur == '0) begin
          r_pend_pop <= stream.tx_valid_i;
        end
      end else if (w_state_nxt != ACTIVE) begin
        r_miso <= 1'b0;
      end

      if (r_rx_valid && stream.rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end

      if (w_sample) begin
        r_rx_shift <= w_rx_byte;
        r_rx_cnt   <= r_rx_cnt + CntW'(1);
        if (r_rx_cnt == '0) begin
          if (r_pend_pop) begin
            r_tx_ready <= 1'b1;
            r_pend_pop <= 1'b0;
          end else begin
            r_unf <= 1'b1;
          end
        end
        if (r_rx_cnt == CntW'(ByteW - 1)) begin
          if (!r_rx_valid || stream.rx_ready_i) begin
            r_rx_data  <= w_rx_byte;
            r_rx_valid <= 1'b1;
          end else begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  assign miso_o            = r_miso;
  assign stream.tx_ready_o = r_tx_ready;
  assign stream.rx_data_o  = r_rx_data;
  assign stream.rx_valid_o = r_rx_valid;
  assign rx_overflow_o     = r_ovf;
  assign tx_underflow_o    = r_unf;

endmodule

// File: tb/tb_spi_device_core.sv
// Randomised SPI host against spi_device_core with a queue-based scoreboard.
module tb_spi_device_core;
  import spi_device_pkg::*;

  logic clk = 1'b0;
  logic rst, en, cpol, cpha, sclk, cs, mosi;
  logic miso, miso_en, rx_ovf, tx_unf, active;

  spi_device_if sif();

  spi_device_core #(.SyncStages(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .cpol_i         (cpol),
    .cpha_i         (cpha),
    .sclk_i         (sclk),
    .cs_i           (cs),
    .mosi_i         (mosi),
    .miso_o         (miso),
    .miso_en_o      (miso_en),
    .stream         (sif.slave),
    .rx_overflow_o  (rx_ovf),
    .tx_underflow_o (tx_unf),
    .active_o       (active)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned n_pop = 0, n_unf = 0, n_ovf = 0;
  int unsigned e_pop = 0, e_unf = 0, e_ovf = 0;
  logic [7:0]  src_q[$];
  logic [7:0]  mdl_tx_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  host_q[$];
  logic        hs, prev_rdy = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_tx(input logic [7:0] b);
    src_q.push_back(b);
    mdl_tx_q.push_back(b);
  endtask

  // Front-end transmit FIFO: front entry leaves only after a valid&&ready handshake.
  always begin
    @(negedge clk);
    hs = sif.tx_valid_i && sif.tx_ready_o;
    @(posedge clk);
    #1;
    if (hs && src_q.size() != 0) begin
      void'(src_q.pop_front());
      n_pop++;
    end
    sif.tx_valid_i = (src_q.size() != 0);
    sif.tx_data_i  = (src_q.size() != 0) ? src_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (sif.tx_ready_o) check("tx_ready_single_cycle", 32'(prev_rdy), 32'd0);
    prev_rdy = sif.tx_ready_o;
    if (rx_ovf) n_ovf++;
    if (tx_unf) n_unf++;
    if (sif.rx_valid_o && sif.rx_ready_i) begin
      if (exp_rx_q.size() == 0) begin
        n_checks++;
        $display("FAIL rx_unexpected: got byte %02h, expected no byte", sif.rx_data_o);
      end else begin
        check("rx_byte", 32'(sif.rx_data_o), 32'(exp_rx_q.pop_front()));
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return 32'({miso, miso_en, active, rx_ovf, tx_unf,
                sif.tx_ready_o, sif.rx_valid_o, sif.rx_data_o});
  endfunction

  // Host sends host_q (nfull whole bytes, then an optional part-bit byte).
  task automatic run_xfer(input bit pol, input bit pha, input int nfull,
                          input int part, input bit hold);
    logic [7:0] exp_miso[$];
    logic [7:0] rd;
    int nbytes, bits;
    nbytes = host_q.size();
    for (int i = 0; i < nbytes; i++) begin
      if (mdl_tx_q.size() != 0) begin
        exp_miso.push_back(mdl_tx_q.pop_front());
        e_pop++;
      end else begin
        exp_miso.push_back(8'h00);
        e_unf++;
      end
      if (i < nfull) begin
        if (!hold || i == 0) exp_rx_q.push_back(host_q[i]);
        else e_ovf++;
      end
    end
    cpol = pol; cpha = pha; sclk = pol; sif.rx_ready_i = !hold;
    tick(8);
    cs = 1'b0;
    tick(8);
    for (int i = 0; i < nbytes; i++) begin
      bits = (i < nfull) ? 8 : part;
      rd = 8'h00;
      for (int b = 0; b < bits; b++) begin
        if (!pha) begin
          mosi = host_q[i][7-b];
          tick(8);
          sclk = ~pol;
          rd = {rd[6:0], miso};
          tick(8);
          sclk = pol;
        end else begin
          tick(8);
          sclk = ~pol;
          mosi = host_q[i][7-b];
          tick(8);
          sclk = pol;
          rd = {rd[6:0], miso};
        end
        if (i == 0 && b == 0) check("active_in_xfer", 32'({active, miso_en}), 32'd3);
      end
      check(bits == 8 ? "miso_byte" : "miso_partial", 32'(rd), 32'(exp_miso[i] >> (8 - bits)));
    end
    tick(8);
    cs = 1'b1;
    tick(8);
    check("idle_after_cs", 32'({active, miso_en, miso}), 32'd0);
    sif.rx_ready_i = 1'b1;
    tick(4);
    check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    check("tx_pop_count", 32'(n_pop), 32'(e_pop));
    check("tx_underflow_count", 32'(n_unf), 32'(e_unf));
    check("rx_overflow_count", 32'(n_ovf), 32'(e_ovf));
    host_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nf, pt, np;
    rst = 1'b1; en = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    cs = 1'b1; mosi = 1'b0; sif.rx_ready_i = 1'b1;
    tick(6);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    tick(4);
    check("idle_outputs", all_outs(), 32'd0);

    push_tx(8'h3C); host_q = '{8'hA5};               run_xfer(0, 0, 1, 0, 0);
    push_tx(8'hF0); host_q = '{8'h81};               run_xfer(1, 1, 1, 0, 0);
    host_q = '{8'h12, 8'h34};                        run_xfer(0, 0, 2, 0, 1);
    host_q = '{8'h5A};                               run_xfer(0, 1, 1, 0, 0);
    push_tx(8'hC3); host_q = '{8'hB7};               run_xfer(0, 0, 0, 5, 0);
    push_tx(8'h2D); host_q = '{8'hE1};               run_xfer(1, 0, 1, 0, 0);
    push_tx(8'h9A); push_tx(8'h55); host_q = '{8'h11}; run_xfer(0, 0, 1, 0, 0);
    host_q = '{8'h22};                               run_xfer(0, 0, 1, 0, 0);

    // Reset after CS entry has peeked a byte: nothing may be consumed.
    push_tx(8'h6E);
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    tick(8);
    cs = 1'b0;
    tick(8);
    check("active_before_reset", 32'(active), 32'd1);
    rst = 1'b1;
    tick(1);
    check("reset_mid_xfer_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    tick(2);
    cs = 1'b1;
    tick(8);
    check("reset_mid_xfer_no_pop", 32'(n_pop), 32'(e_pop));

    // Disabled block ignores a whole clocked byte.
    en = 1'b0;
    cs = 1'b0;
    tick(8);
    for (int b = 0; b < 8; b++) begin
      tick(8); sclk = 1'b1; tick(8); sclk = 1'b0;
    end
    check("disabled_inactive", 32'({active, miso_en, sif.rx_valid_o}), 32'd0);
    tick(8);
    cs = 1'b1;
    tick(8);
    en = 1'b1;
    check("disabled_no_underflow", 32'(n_unf), 32'(e_unf));
    check("disabled_no_pop", 32'(n_pop), 32'(e_pop));

    for (int t = 0; t < 16; t++) begin
      np = $urandom_range(0, 3);
      for (int k = 0; k < np; k++) push_tx(8'($urandom));
      nf = $urandom_range(0, 3);
      pt = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 7)) : 0;
      if (nf == 0 && pt == 0) nf = 1;
      for (int k = 0; k < nf + (pt != 0 ? 1 : 0); k++) host_q.push_back(8'($urandom));
      run_xfer(1'($urandom), 1'($urandom), nf, pt, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
